// File: rtl/noc_tx_arbiter.sv
// -----------------------------------------------------------------------------
// noc_tx_arbiter
//
// Merges NUM_CH per-source flit queues into the single inter-device transmit
// stream. Channel 0 (ack) has strict priority. Channels 1..NUM_CH-1 are served
// round-robin. Packets are never interleaved: once a non-tail flit is accepted,
// the arbiter locks onto that channel until its tail flit passes. A starvation
// guard limits how many consecutive ch0 packets may pass while another channel
// waits. The output stage is a single register slice.
//
// Optional feature: define NOC_TX_ARB_STATS_EN to add per-channel 16-bit
// saturating transfer counters (grant_cnt) and their clear input (stats_clr).
//
// Ports:
//   nocclk          clock
//   rst             synchronous active-high reset
//   in_flit         packed input flits, channel i at [i*FLIT_W +: FLIT_W]
//   in_last         per-channel packet-tail flag
//   in_vld/in_rdy   per-channel input handshake (at most one in_rdy bit set)
//   out_flit        registered output flit
//   out_last        registered tail flag
//   out_ch          source channel of out_flit
//   out_vld/out_rdy output handshake
//   locked          arbiter is mid-packet
//   dbg_state       FSM state (0 = IDLE, 1 = LOCKED)
//   dbg_rr_ptr      round-robin start pointer
//   dbg_starve_cnt  consecutive ch0 tails passed while others waited
//   stats_clr       (stats build) synchronous counter clear
//   grant_cnt       (stats build) per-channel transfer counters, 16 bits each
//
// Handshake: a flit moves across an interface in a cycle where valid and
// ready are both high at the rising edge. A source holding valid keeps its
// data stable until it sees ready; ready may depend combinationally on valid,
// but valid never depends on ready.
// -----------------------------------------------------------------------------
module noc_tx_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int FLIT_W       = 128,
  parameter int STARVE_LIMIT = 8,
  localparam int CH_W        = $clog2(NUM_CH),
  localparam int SC_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
  input  logic                     nocclk,
  input  logic                     rst,
  input  logic [NUM_CH*FLIT_W-1:0] in_flit,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [NUM_CH-1:0]        in_vld,
  output logic [NUM_CH-1:0]        in_rdy,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [0:0]               dbg_state,
  output logic [CH_W-1:0]          dbg_rr_ptr,
  output logic [SC_W-1:0]          dbg_starve_cnt,
  output logic                     locked
`ifdef NOC_TX_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_CH*16-1:0]     grant_cnt
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [SC_W-1:0]   starve_cnt;

  logic              accept;
  logic              boost;
  logic              rr_found;
  logic [CH_W-1:0]   rr_ch;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;
  logic              xfer;
  logic [FLIT_W-1:0] sel_flit;
  logic              sel_last;

  // The output register can take a new flit when empty or draining this cycle.
  assign accept = !out_vld || out_rdy;

  // Round-robin search over ch1..NUM_CH-1, starting at rr_ptr and wrapping
  // from NUM_CH-1 back to 1 (ch0 is never part of the ring).
  always_comb begin
    int idx;
    rr_found = 1'b0;
    rr_ch    = '0;
    idx      = 0;
    for (int off = 0; off < NUM_CH - 1; off++) begin
      idx = ((int'(rr_ptr) - 1 + off) % (NUM_CH - 1)) + 1;
      if (!rr_found && in_vld[CH_W'(idx)]) begin
        rr_found = 1'b1;
        rr_ch    = CH_W'(idx);
      end
    end
  end

  // Boost only fires when some other channel actually waits, so an idle
  // system never gets ch0 delayed by a stale counter.
  assign boost = (STARVE_LIMIT != 0) &&
                 (starve_cnt == SC_W'(STARVE_LIMIT)) &&
                 (|in_vld[NUM_CH-1:1]);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    if (state == ST_LOCKED) begin
      gnt_vld = in_vld[lock_ch];
      gnt_ch  = lock_ch;
    end else if (boost) begin
      gnt_vld = rr_found;
      gnt_ch  = rr_ch;
    end else if (in_vld[0]) begin
      gnt_vld = 1'b1;
      gnt_ch  = '0;
    end else begin
      gnt_vld = rr_found;
      gnt_ch  = rr_ch;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_rdy[i] = !rst && accept && gnt_vld && (gnt_ch == CH_W'(i));
    end
  end

  assign xfer = |(in_vld & in_rdy);

  // Explicit mux avoids a variable-width part-select on the packed bus.
  always_comb begin
    sel_flit = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_ch == CH_W'(i)) begin
        sel_flit = in_flit[i*FLIT_W +: FLIT_W];
        sel_last = in_last[i];
      end
    end
  end

  // Output register slice
  always_ff @(posedge nocclk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_flit <= '0;
      out_last <= 1'b0;
      out_ch   <= '0;
    end else if (accept) begin
      out_vld <= xfer;
      if (xfer) begin
        out_flit <= sel_flit;
        out_last <= sel_last;
        out_ch   <= gnt_ch;
      end
    end
  end

  // Packet lock FSM
  always_ff @(posedge nocclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
    end else if (xfer) begin
      if (state == ST_IDLE && !sel_last) begin
        state   <= ST_LOCKED;
        lock_ch <= gnt_ch;
      end else if (state == ST_LOCKED && sel_last) begin
        state <= ST_IDLE;
      end
    end
  end

  // Round-robin pointer and starvation counter advance on packet tails only,
  // so a locked packet counts as a single service event.
  always_ff @(posedge nocclk) begin
    if (rst) begin
      rr_ptr     <= CH_W'(1);
      starve_cnt <= '0;
    end else if (xfer && sel_last) begin
      if (gnt_ch == '0) begin
        if ((|in_vld[NUM_CH-1:1]) && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
          starve_cnt <= starve_cnt + SC_W'(1);
        end
      end else begin
        starve_cnt <= '0;
        rr_ptr     <= (gnt_ch == CH_W'(NUM_CH - 1)) ? CH_W'(1) : gnt_ch + CH_W'(1);
      end
    end
  end

  assign locked         = (state == ST_LOCKED);
  assign dbg_state      = state;
  assign dbg_rr_ptr     = rr_ptr;
  assign dbg_starve_cnt = starve_cnt;

`ifdef NOC_TX_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_CH];

  // A clear in the same cycle as a transfer wins; that increment is dropped.
  always_ff @(posedge nocclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || stats_clr) begin
        cnt_q[i] <= '0;
      end else if (in_vld[i] && in_rdy[i] && (cnt_q[i] != 16'hffff)) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: doc/noc_tx_arbiter.md
Name: noc_tx_arbiter

Overview:
Parametrised N-channel transmit arbiter. It merges the per-source flit queues (ack, waiting-ack retransmit, forwarded, cpu-to-noc) into the single inter-device transmit stream. Channel 0 has strict priority. Other channels are served round-robin, with wormhole packet locking and a starvation guard. The output is registered, sitting between the flit queues and the interdevice controller.

Parameters:
- NUM_CH, 4, number of input channels (>=2); channel 0 = ack, strict priority.
- FLIT_W, 128, flit width in bits (matches types::flit_t).
- STARVE_LIMIT, 8, consecutive ch0 packet tails tolerated while any ch1..NUM_CH-1 waits; 0 = guard disabled.
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden).

Ports:
- nocclk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_flit  in  NUM_CH*FLIT_W  packed input flits, channel i at [i*FLIT_W +: FLIT_W]
- in_last  in  NUM_CH  flit is packet tail (single-flit packet = 1)
- in_vld  in  NUM_CH  per-channel valid
- in_rdy  out  NUM_CH  per-channel ready, at most one bit set
- out_flit  out  FLIT_W  registered output flit
- out_last  out  1  registered tail flag
- out_ch  out  CH_W  source channel of out_flit
- out_vld  out  1  output valid
- out_rdy  in  1  downstream ready
- locked  out  1  arbiter is mid-packet

Behaviour:
- Single clock nocclk. Reset is synchronous and active-high on rst.
- Reset values:
  - out_vld=0, out_flit=0, out_last=0, out_ch=0, locked=0.
  - State IDLE, rr_ptr=1, starve_cnt=0.
  - in_rdy=0 while rst=1.
- Slot free: accept = !out_vld || out_rdy.
- Transfer on channel g: in_vld[g] && in_rdy[g]. The flit appears on out_* on the next cycle (latency 1).
- in_rdy is combinational from registered state and in_vld. in_rdy[g]=1 only for the granted channel g, and only when accept=1.
- With out_vld=1 && out_rdy=0, out_* hold stable and all in_rdy=0.
- Arbitration in IDLE (evaluated whenever accept=1):
  1. Boost case: starve_cnt==STARVE_LIMIT, STARVE_LIMIT!=0, and any of ch1..N-1 valid. Grant round-robin among ch1..N-1, starting at rr_ptr.
  2. Otherwise, if in_vld[0]: grant ch0.
  3. Otherwise: grant round-robin among ch1..N-1, starting at rr_ptr, ascending with wrap from N-1 to 1.
  4. No valid channel: no grant, out_vld deasserts next cycle if out_rdy.
- State machine:
  - IDLE: a transfer with in_last=0 moves to LOCKED with lock_ch=g; a transfer with in_last=1 stays in IDLE.
  - LOCKED: only lock_ch is eligible; ch0 priority and the boost are ignored. A transfer with in_last=1 returns to IDLE. A gap in lock_ch valid keeps LOCKED.
  - locked output = (state==LOCKED).
- rr_ptr update: on tail transfer from channel k>=1, rr_ptr = (k==N-1) ? 1 : k+1. Unchanged otherwise.
- starve_cnt update:
  - Tail transfer from ch0 while any in_vld[1..N-1]=1: increment, saturating at STARVE_LIMIT.
  - Tail transfer from any k>=1: clear to 0.
  - Otherwise: hold.
- Simultaneous events:
  - Output drain and new accept in the same cycle are allowed, giving full throughput of 1 flit/cycle.
  - rst overrides everything, including a mid-packet lock; a partially sent packet is abandoned and no flits are replayed.
- NUM_CH==2: round-robin degenerates to ch1 only; rr_ptr is constant 1.

Optional Feature:
- Macro NOC_TX_ARB_STATS_EN.
- When defined: adds output port grant_cnt (NUM_CH*16) holding per-channel 16-bit saturating counters of transferred flits. Counters are cleared by rst and also by a new input stats_clr (1 bit, synchronous, same-cycle increment is lost).
- When undefined: neither port exists and there are no counter registers. Functional behaviour is otherwise identical.

Test Plan:
- Priority: reset, then ch0 and ch2 valid with single-flit packets (last=1), out_rdy=1. Required: ch0 flit on out_* at cycle 1, ch2 flit at cycle 2 once ch0 drops valid; out_ch 0 then 2.
- Round-robin: ch1, ch2, ch3 continuously valid with single-flit packets, ch0 idle. Required: out_ch sequence 1,2,3,1,2,3 at 1 flit/cycle.
- Wormhole lock: ch2 sends 3-flit packet (last=0,0,1) while ch0 asserts valid after flit 1. Required: locked=1 for flits 1-2, ch0 served only after ch2 tail; no interleaving.
- Starvation: STARVE_LIMIT=2, ch0 and ch1 continuously valid with single-flit packets. Required: out_ch 0,0,1,0,0,1.
- Backpressure: out_rdy=0 for 5 cycles with out_vld=1. Required: out_flit/out_ch stable, in_rdy=0. On out_rdy=1, the next flit follows in the same cycle as the drain, with no bubble.
- Reset mid-packet: assert rst while LOCKED on ch3. Required: next cycle out_vld=0, locked=0, rr_ptr=1; a subsequent ch1 packet is granted normally.
